// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader for the mips32 core: assembles big-endian words,
// writes them to instruction memory from address 0, and releases the CPU after HLT.
module mips32_prog_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {IDLE, LOAD, WRITE, RUN, ERR} state_t;

   localparam logic [ADDR_W:0] LAST_WORD = {1'b0, {ADDR_W{1'b1}}};

   state_t              state_q;
   logic [23:0]         buf_q;
   logic [1:0]          idx_q;
   logic [ADDR_W:0]     word_count_q;
   logic                in_ready_q, mem_we_q, cpu_hold_q, load_done_q, load_err_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [31:0]         mem_wdata_q;
   logic [31:0]         word_d;

   assign word_d = {buf_q, in_byte};

   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q      <= IDLE;
         buf_q        <= '0;
         idx_q        <= '0;
         word_count_q <= '0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b1;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE, RUN, ERR: begin
               if (start) begin
                  state_q      <= LOAD;
                  idx_q        <= '0;
                  word_count_q <= '0;
                  in_ready_q   <= 1'b1;
                  cpu_hold_q   <= 1'b1;
                  load_done_q  <= 1'b0;
                  load_err_q   <= 1'b0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  buf_q <= word_d[23:0];
                  idx_q <= idx_q + 2'd1;
                  if (idx_q == 2'd3) begin
                     state_q     <= WRITE;
                     in_ready_q  <= 1'b0;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= word_count_q[ADDR_W-1:0];
                     mem_wdata_q <= word_d;
                  end
               end
            end
            WRITE: begin
               mem_we_q     <= 1'b0;
               word_count_q <= word_count_q + 1'b1;
               // HLT wins over a full memory: a program ending exactly at the top is valid
               if (mem_wdata_q[31:26] == 6'b111111) begin
                  state_q     <= RUN;
                  cpu_hold_q  <= 1'b0;
                  load_done_q <= 1'b1;
               end else if (word_count_q == LAST_WORD) begin
                  state_q    <= ERR;
                  load_err_q <= 1'b1;
               end else begin
                  state_q    <= LOAD;
                  in_ready_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;
   assign word_count = word_count_q;

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Program loader that sits directly upstream of the `mips32` pipeline. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them into the processor's instruction memory starting at address 0. It holds the processor halted while loading. It releases the processor once the HLT instruction (opcode `6'h3f`) has been written, and flags an error if memory fills without one.

## Interface

**Parameters**
- `ADDR_W`, default 10: instruction memory address width. Depth is `2**ADDR_W` words.

**Ports**
- `clk1`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: one-cycle pulse that begins a new load.
- `in_valid`, input, 1: `in_byte` is valid.
- `in_byte`, input, 8: stream byte. The first byte of each word is bits [31:24].
- `in_ready`, output, 1: loader accepts a byte this cycle.
- `mem_we`, output, 1: instruction memory write enable.
- `mem_addr`, output, `ADDR_W`: write address.
- `mem_wdata`, output, 32: write data.
- `cpu_hold`, output, 1: high keeps the processor halted with PC=0; low releases it.
- `load_done`, output, 1: load completed with HLT; level signal.
- `load_err`, output, 1: memory full without HLT; level signal.
- `word_count`, output, `ADDR_W+1`: number of words written in the current load.

## Operation

**States:** IDLE, LOAD, WRITE, RUN, ERR.

**Reset values:** state=IDLE, `cpu_hold`=1, every other output 0, byte index=0.

**IDLE**
- `in_ready`=0.
- `start` → LOAD; clear `word_count`, byte index, `load_done`, `load_err`.

**LOAD**
- `in_ready`=1.
- Each handshake (`in_valid && in_ready`) shifts `in_byte` into the word buffer (`buf <= {buf[23:0], in_byte}`) and increments the 2-bit byte index.
- A handshake at index 3 → WRITE.

**WRITE** (exactly one cycle)
- `in_ready`=0, `mem_we`=1, `mem_addr`=`word_count[ADDR_W-1:0]`, `mem_wdata`=assembled word. `word_count` increments at the end of the cycle.
- Next state:
  - word[31:26]==`6'b111111` → RUN;
  - else `word_count`==`2**ADDR_W - 1` (this write was to the last address) → ERR;
  - else → LOAD.

**RUN**
- `cpu_hold`=0, `load_done`=1, `in_ready`=0.

**ERR**
- `cpu_hold`=1, `load_err`=1, `in_ready`=0.

**Restart and ignored inputs**
- `start` in RUN or ERR → LOAD with counters and flags cleared. `cpu_hold` returns to 1 in the same edge.
- `start` in LOAD or WRITE is ignored.
- `in_valid` is ignored outside LOAD; the byte is not consumed.

**Reset mid-load:** any partial word is discarded and no write occurs. Memory contents written earlier are not erased.

**Widths:** `word_count` is `ADDR_W+1` bits so a full memory (`2**ADDR_W`) is representable. No wrap-around of `mem_addr` is possible.

## Timing

- The fourth byte accepted at edge N puts WRITE in cycle N+1 (`mem_we`=1). At N+2 the loader is back in LOAD with `in_ready`=1.
- Maximum throughput: 4 bytes per 5 cycles.
- `mem_we` is never high for two consecutive cycles.
- Release latency: the HLT word's WRITE cycle is followed by `cpu_hold`=0 on the next edge. The processor sees its memory fully written before release.
- `in_ready` is a function of state only, with no combinational path from `in_valid`.
- `rst` has priority over `start` in the same cycle.

## Test plan

1. **Normal load.** Stream the 9-word program 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 (36 bytes, `in_valid` held high). Required: 9 `mem_we` pulses at addresses 0–8 with exactly these words; `word_count`=9; `load_done`=1 and `cpu_hold`=0 one cycle after the last WRITE.
2. **Gapped valid.** Same stream with `in_valid` low every other cycle. Required: identical memory contents; no byte dropped or duplicated.
3. **Overflow.** With `ADDR_W`=2, send 4 non-HLT words (00000001..00000004). Required: writes to addresses 0–3, then `load_err`=1, `cpu_hold`=1, `in_ready`=0, `word_count`=4.
4. **Reset mid-word.** Send bytes fc 00, then assert `rst`. Required: no `mem_we`, state IDLE, `cpu_hold`=1, all other outputs 0.
5. **Restart.** After test 1 completes, pulse `start`. Required: next cycle `cpu_hold`=1, `load_done`=0, `word_count`=0. A single word fc000000 then writes address 0 and reaches RUN.
6. **Ignored start.** Pulse `start` during LOAD after 2 bytes. Required: the byte index stays 2 and the word completes normally.
